// File: rtl/pbus_pkg.sv
// ---------------------------------------------------------------------------
// pbus_pkg
// Shared constants and types for the peripheral-page arbiter.
//   - bus widths and slave count
//   - slave strobe indices (bit positions in s_stb)
//   - inclusive base/limit of every mapped region
//   - arbiter FSM state encoding
//   - in_range() helper used by the address decoder
// ---------------------------------------------------------------------------
package pbus_pkg;

    localparam int ADR_W = 11;
    localparam int DAT_W = 8;
    localparam int SLV_N = 7;
    localparam int CNT_W = 4;

    // Strobe bit positions.
    localparam int SLV_SPI     = 0;
    localparam int SLV_GPIO    = 1;
    localparam int SLV_TIMER   = 2;
    localparam int SLV_INTC    = 3;
    localparam int SLV_CLKC    = 4;
    localparam int SLV_SYSCALL = 5;
    localparam int SLV_SPM     = 6;

    // Inclusive region bounds.
    localparam logic [ADR_W-1:0] SPI_BASE      = 11'h000;
    localparam logic [ADR_W-1:0] SPI_LIMIT     = 11'h007;
    localparam logic [ADR_W-1:0] GPIO_BASE     = 11'h008;
    localparam logic [ADR_W-1:0] GPIO_LIMIT    = 11'h00F;
    localparam logic [ADR_W-1:0] TIMER_BASE    = 11'h010;
    localparam logic [ADR_W-1:0] TIMER_LIMIT   = 11'h017;
    localparam logic [ADR_W-1:0] INTC_BASE     = 11'h018;
    localparam logic [ADR_W-1:0] INTC_LIMIT    = 11'h01F;
    localparam logic [ADR_W-1:0] CLKC_BASE     = 11'h020;
    localparam logic [ADR_W-1:0] CLKC_LIMIT    = 11'h027;
    localparam logic [ADR_W-1:0] SYSCALL_BASE  = 11'h300;
    localparam logic [ADR_W-1:0] SYSCALL_LIMIT = 11'h3FF;
    localparam logic [ADR_W-1:0] SPM_BASE      = 11'h400;
    localparam logic [ADR_W-1:0] SPM_LIMIT     = 11'h7FF;

    // Arbiter states.
    //   ST_IDLE : no owner, arbitrate between requesters
    //   ST_XFER : slave strobe asserted, wait-state counter running
    //   ST_ACK  : single acknowledge cycle to the owner
    //   ST_OWN  : owner still holds CYC; next STB starts a transfer directly
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_ACK  = 2'd2,
        ST_OWN  = 2'd3
    } state_t;

    function automatic logic in_range(input logic [ADR_W-1:0] adr,
                                      input logic [ADR_W-1:0] base,
                                      input logic [ADR_W-1:0] limit);
        return (adr >= base) && (adr <= limit);
    endfunction

endpackage

// File: rtl/pbus_addr_decode.sv
// ---------------------------------------------------------------------------
// pbus_addr_decode
// Purely combinational decode of an 11-bit peripheral-page address into a
// one-hot slave select. Addresses outside every region give sel = 0 and
// unmapped = 1.
// Ports:
//   adr      in  11  address to decode
//   sel      out  7  one-hot slave select (SPI..SPM, bit order as s_stb)
//   unmapped out  1  address hits no region
// ---------------------------------------------------------------------------
module pbus_addr_decode
    import pbus_pkg::*;
(
    input  logic [ADR_W-1:0] adr,
    output logic [SLV_N-1:0] sel,
    output logic             unmapped
);

    always_comb begin
        sel              = '0;
        sel[SLV_SPI]     = in_range(adr, SPI_BASE,     SPI_LIMIT);
        sel[SLV_GPIO]    = in_range(adr, GPIO_BASE,    GPIO_LIMIT);
        sel[SLV_TIMER]   = in_range(adr, TIMER_BASE,   TIMER_LIMIT);
        sel[SLV_INTC]    = in_range(adr, INTC_BASE,    INTC_LIMIT);
        sel[SLV_CLKC]    = in_range(adr, CLKC_BASE,    CLKC_LIMIT);
        sel[SLV_SYSCALL] = in_range(adr, SYSCALL_BASE, SYSCALL_LIMIT);
        sel[SLV_SPM]     = in_range(adr, SPM_BASE,     SPM_LIMIT);
        unmapped         = ~|sel;
    end

endmodule

// File: rtl/pbus_arbiter.sv
// ---------------------------------------------------------------------------
// pbus_arbiter
// Two-master Wishbone arbiter and address decoder for the 11-bit peripheral
// page. Grants one master at a time (round-robin on ties), drives one-hot
// slave strobes, counts per-region wait states, registers read data per
// master and is the only source of ACK/ERR on this page.
//
// Handshake: a master requests with cyc&stb and must hold address, data and
// we stable until it sees ack. ack (and err for unmapped addresses) is high
// for exactly one cycle. While a master keeps cyc high after its ack it keeps
// the grant, and its next stb starts a transfer without re-arbitration.
// Dropping cyc before ack aborts the transfer and no ack is produced.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   m0_* / m1_*               master ports (adr, dat_i, dat_o, we, cyc, stb,
//                             ack, err); M0 = core, M1 = DMA/debug
//   s_adr, s_dat_o, s_we      owner's address/write data/we to the slaves
//   s_cyc, s_stb[6:0]         cycle and one-hot slave strobes
//   s_first                   first cycle of each transfer
//   s_dat_i[55:0]             packed slave read data, slave k at [8k+7:8k]
//   gnt[1:0]                  current owner {M1,M0}, 00 when idle
//   err_flag, err_addr, err_clr  sticky unmapped-access flag, address, clear
// ---------------------------------------------------------------------------
module pbus_arbiter
    import pbus_pkg::*;
#(
    parameter int WS_PERIPH  = 1,
    parameter int WS_SYSCALL = 0,
    parameter int WS_SPM     = 0
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [ADR_W-1:0]       m0_adr,
    input  logic [DAT_W-1:0]       m0_dat_i,
    output logic [DAT_W-1:0]       m0_dat_o,
    input  logic                   m0_we,
    input  logic                   m0_cyc,
    input  logic                   m0_stb,
    output logic                   m0_ack,
    output logic                   m0_err,

    input  logic [ADR_W-1:0]       m1_adr,
    input  logic [DAT_W-1:0]       m1_dat_i,
    output logic [DAT_W-1:0]       m1_dat_o,
    input  logic                   m1_we,
    input  logic                   m1_cyc,
    input  logic                   m1_stb,
    output logic                   m1_ack,
    output logic                   m1_err,

    output logic [ADR_W-1:0]       s_adr,
    output logic [DAT_W-1:0]       s_dat_o,
    output logic                   s_we,
    output logic                   s_cyc,
    output logic [SLV_N-1:0]       s_stb,
    output logic                   s_first,
    input  logic [SLV_N*DAT_W-1:0] s_dat_i,

    output logic [1:0]             gnt,
    output logic                   err_flag,
    output logic [ADR_W-1:0]       err_addr,
    input  logic                   err_clr
);

    // -----------------------------------------------------------------------
    // State and registers
    // -----------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [1:0]         last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SLV_N-1:0]   sel_q, sel_d;
    logic               unm_q, unm_d;
    logic               first_q, first_d;
    logic [DAT_W-1:0]   m0_rd_q, m1_rd_q;
    logic               err_flag_q;
    logic [ADR_W-1:0]   err_addr_q;

    logic               ld_rd;
    logic               set_err;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic req0, req1;
    logic pick0, pick1;

    assign req0  = m0_cyc & m0_stb;
    assign req1  = m1_cyc & m1_stb;
    // On a tie the master that did not own the bus last time wins.
    assign pick1 = req1 & (~req0 | last_q[0]);
    assign pick0 = req0 & ~pick1;

    // -----------------------------------------------------------------------
    // Owner mux. In IDLE the decoder looks at the arbitration winner so the
    // wait-state count can be loaded on the granting edge; otherwise it looks
    // at the registered owner.
    // -----------------------------------------------------------------------
    logic               dec_m1;
    logic [ADR_W-1:0]   dec_adr;
    logic [SLV_N-1:0]   dec_sel;
    logic               dec_unm;

    assign dec_m1  = (state_q == ST_IDLE) ? pick1 : gnt_q[1];
    assign dec_adr = dec_m1 ? m1_adr : m0_adr;

    pbus_addr_decode u_decode (
        .adr      (dec_adr),
        .sel      (dec_sel),
        .unmapped (dec_unm)
    );

    logic [ADR_W-1:0]   own_adr;
    logic [DAT_W-1:0]   own_dat;
    logic               own_we;
    logic               own_cyc;
    logic               own_stb;

    assign own_adr = gnt_q[1] ? m1_adr   : m0_adr;
    assign own_dat = gnt_q[1] ? m1_dat_i : m0_dat_i;
    assign own_we  = gnt_q[1] ? m1_we    : m0_we;
    assign own_cyc = gnt_q[1] ? m1_cyc   : (gnt_q[0] & m0_cyc);
    assign own_stb = gnt_q[1] ? m1_stb   : (gnt_q[0] & m0_stb);

    // Wait states per region; unmapped accesses complete without waiting.
    function automatic logic [CNT_W-1:0] ws_of(input logic [SLV_N-1:0] sel,
                                               input logic             unm);
        if (unm)
            return '0;
        else if (sel[SLV_SPM])
            return CNT_W'(WS_SPM);
        else if (sel[SLV_SYSCALL])
            return CNT_W'(WS_SYSCALL);
        else
            return CNT_W'(WS_PERIPH);
    endfunction

    // Read-data mux: AND-OR over the registered one-hot select, so an
    // unmapped access (sel_q == 0) naturally returns 0x00.
    logic [DAT_W-1:0] slv_rd;

    always_comb begin
        slv_rd = '0;
        for (int k = 0; k < SLV_N; k++) begin
            if (sel_q[k])
                slv_rd = slv_rd | s_dat_i[DAT_W*k +: DAT_W];
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        unm_d   = unm_q;
        first_d = 1'b0;
        ld_rd   = 1'b0;
        set_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick0 | pick1) begin
                    gnt_d   = {pick1, pick0};
                    last_d  = {pick1, pick0};
                    cnt_d   = ws_of(dec_sel, dec_unm);
                    sel_d   = dec_sel;
                    unm_d   = dec_unm;
                    first_d = 1'b1;
                    state_d = ST_XFER;
                end
            end

            ST_XFER: begin
                // Abort takes priority over completion, even on the last
                // wait-state cycle.
                if (!own_cyc) begin
                    gnt_d   = 2'b00;
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    ld_rd   = 1'b1;
                    set_err = unm_q;
                    state_d = ST_ACK;
                end
            end

            ST_ACK: begin
                state_d = ST_OWN;
            end

            ST_OWN: begin
                if (!own_cyc) begin
                    gnt_d   = 2'b00;
                    state_d = ST_IDLE;
                end else if (own_stb) begin
                    cnt_d   = ws_of(dec_sel, dec_unm);
                    sel_d   = dec_sel;
                    unm_d   = dec_unm;
                    first_d = 1'b1;
                    state_d = ST_XFER;
                end
            end

            default: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 2'b10;
            cnt_q   <= '0;
            sel_q   <= '0;
            unm_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            unm_q   <= unm_d;
            first_q <= first_d;
        end
    end

    // Per-master read registers: each holds its value until that master's
    // next completed transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_rd_q <= '0;
            m1_rd_q <= '0;
        end else if (ld_rd) begin
            if (gnt_q[0])
                m0_rd_q <= slv_rd;
            if (gnt_q[1])
                m1_rd_q <= slv_rd;
        end
    end

    // Sticky error: a new unmapped access beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else if (set_err) begin
            err_flag_q <= 1'b1;
            err_addr_q <= own_adr;
        end else if (err_clr) begin
            err_flag_q <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (decoded from registered state so reset clears them at once)
    // -----------------------------------------------------------------------
    logic in_xfer;
    logic in_ack;

    assign in_xfer  = (state_q == ST_XFER);
    assign in_ack   = (state_q == ST_ACK);

    assign s_cyc    = in_xfer;
    assign s_stb    = in_xfer ? sel_q   : '0;
    assign s_first  = in_xfer & first_q;
    assign s_adr    = in_xfer ? own_adr : '0;
    assign s_dat_o  = in_xfer ? own_dat : '0;
    assign s_we     = in_xfer & own_we;

    assign m0_ack   = in_ack & gnt_q[0];
    assign m1_ack   = in_ack & gnt_q[1];
    assign m0_err   = m0_ack & unm_q;
    assign m1_err   = m1_ack & unm_q;
    assign m0_dat_o = m0_rd_q;
    assign m1_dat_o = m1_rd_q;

    assign gnt      = gnt_q;
    assign err_flag = err_flag_q;
    assign err_addr = err_addr_q;

endmodule
